// File: rtl/bit_scan_pkg.sv
// rtl/bit_scan_pkg.sv - shared types for the bit scan encoder
//
// Purpose: scan state encoding used by bit_scan_encoder.
// Ports: none (package).

package bit_scan_pkg;

  // S_IDLE: no vector held. S_SCAN: residual mask is being emitted.
  typedef enum logic {S_IDLE, S_SCAN} scan_state_t;

endpackage

// File: rtl/bit_scan_encoder_prio_enc.sv
// rtl/bit_scan_encoder_prio_enc.sv - parametrised combinational priority encoder
//
// Purpose: generalised form of the 8-bit priority encoder.
// Ports:
//   vec   in  WIDTH  vector to encode
//   idx   out POS_W  index of the priority set bit (0 when vec is zero)
//   any   out 1      at least one bit set
//   multi out 1      more than one bit set

module prio_enc #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1,
  parameter int POS_W     = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [POS_W-1:0] idx,
  output logic             any,
  output logic             multi
);

  // The loop walks toward the winning end so the last match assigned wins.
  always_comb begin
    idx = '0;
    if (LSB_FIRST) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (vec[i]) idx = POS_W'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (vec[i]) idx = POS_W'(i);
      end
    end
  end

  assign any = |vec;

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = |(vec & (vec - WIDTH'(1)));

endmodule

// File: rtl/bit_scan_encoder.sv
// rtl/bit_scan_encoder.sv - streams the index of every set bit of a vector
//
// Purpose: accepts a WIDTH-bit vector over valid/ready and emits one beat per
// set bit, in priority order (lowest first when LSB_FIRST = 1). An all-zero
// vector produces a single beat flagged with zero.
// Ports:
//   clk       in  1      clock, rising edge
//   rst       in  1      asynchronous active-high reset
//   in_valid  in  1      input vector present
//   in_ready  out 1      block can accept a vector
//   in        in  WIDTH  vector to scan
//   pos_valid out 1      pos/pos_last/zero valid
//   pos_ready in  1      consumer accepts current beat
//   pos       out POS_W  index of current set bit
//   pos_last  out 1      final beat of this vector
//   zero      out 1      accepted vector was all-zero

module bit_scan_encoder
  import bit_scan_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1,
  parameter int POS_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  output logic             pos_valid,
  input  logic             pos_ready,
  output logic [POS_W-1:0] pos,
  output logic             pos_last,
  output logic             zero
);

  scan_state_t      state, state_next;
  logic [WIDTH-1:0] mask, mask_next;
  logic             zflag, zflag_next;

  logic [POS_W-1:0] enc_idx;
  logic             enc_any;
  logic             enc_multi;
  logic [WIDTH-1:0] onehot;

  prio_enc #(
    .WIDTH    (WIDTH),
    .LSB_FIRST(LSB_FIRST),
    .POS_W    (POS_W)
  ) u_prio_enc (
    .vec  (mask),
    .idx  (enc_idx),
    .any  (enc_any),
    .multi(enc_multi)
  );

  assign onehot = WIDTH'(1) << enc_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      mask  <= '0;
      zflag <= 1'b0;
    end else begin
      state <= state_next;
      mask  <= mask_next;
      zflag <= zflag_next;
    end
  end

  always_comb begin
    state_next = state;
    mask_next  = mask;
    zflag_next = zflag;
    in_ready   = 1'b0;
    pos_valid  = 1'b0;
    pos        = '0;
    pos_last   = 1'b0;
    zero       = 1'b0;

    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
      end
      S_SCAN: begin
        pos_valid = 1'b1;
        pos       = enc_idx;
        pos_last  = !enc_multi;
        zero      = zflag;
        if (pos_ready) begin
          // The zero-vector beat has nothing to clear.
          if (enc_any) mask_next = mask & ~onehot;
          if (!enc_multi) begin
            in_ready   = 1'b1;
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase

    // A load on the final beat's edge overrides the return to idle,
    // giving back-to-back vectors without a bubble.
    if (in_valid && in_ready) begin
      mask_next  = in;
      zflag_next = (in == '0);
      state_next = S_SCAN;
    end
  end

endmodule

// File: tb/tb_bit_scan_encoder.sv
// tb/tb_bit_scan_encoder.sv - scoreboard bench for bit_scan_encoder

module tb_bit_scan_encoder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // a: WIDTH 8, LSB first
  logic       a_in_valid, a_in_ready, a_pos_valid, a_pos_ready, a_pos_last, a_zero;
  logic [7:0] a_in;
  logic [2:0] a_pos;
  // b: WIDTH 8, MSB first
  logic       b_in_valid, b_in_ready, b_pos_valid, b_pos_ready, b_pos_last, b_zero;
  logic [7:0] b_in;
  logic [2:0] b_pos;
  // c: WIDTH 16, LSB first
  logic        c_in_valid, c_in_ready, c_pos_valid, c_pos_ready, c_pos_last, c_zero;
  logic [15:0] c_in;
  logic [3:0]  c_pos;

  bit_scan_encoder #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in(a_in),
    .pos_valid(a_pos_valid), .pos_ready(a_pos_ready), .pos(a_pos),
    .pos_last(a_pos_last), .zero(a_zero));

  bit_scan_encoder #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in(b_in),
    .pos_valid(b_pos_valid), .pos_ready(b_pos_ready), .pos(b_pos),
    .pos_last(b_pos_last), .zero(b_zero));

  bit_scan_encoder #(.WIDTH(16), .LSB_FIRST(1'b1)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in(c_in),
    .pos_valid(c_pos_valid), .pos_ready(c_pos_ready), .pos(c_pos),
    .pos_last(c_pos_last), .zero(c_zero));

  typedef struct {
    int pos;
    bit last;
    bit zero;
    bit gapless;
  } beat_t;

  beat_t qa[$], qb[$], qc[$];
  int tests = 0;
  int fails = 0;
  int last_beat_a = -10;

  function automatic void check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic beat_t mk(int p, bit l, bit z, bit g);
    beat_t b;
    b.pos = p; b.last = l; b.zero = z; b.gapless = g;
    return b;
  endfunction

  // Monitors: compare every presented beat against the queue head; pop on handshake.
  always @(negedge clk) begin
    if (!rst && a_pos_valid) begin
      if (qa.size() == 0) begin
        check("a_unexpected_beat_pos", int'(a_pos), -1);
      end else begin
        check("a_pos", int'(a_pos), qa[0].pos);
        check("a_pos_last", int'(a_pos_last), int'(qa[0].last));
        check("a_zero", int'(a_zero), int'(qa[0].zero));
        if (a_pos_ready) begin
          if (qa[0].gapless) check("a_gap_cycles", cyc - last_beat_a, 1);
          last_beat_a = cyc;
          void'(qa.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_pos_valid) begin
      if (qb.size() == 0) begin
        check("b_unexpected_beat_pos", int'(b_pos), -1);
      end else begin
        check("b_pos", int'(b_pos), qb[0].pos);
        check("b_pos_last", int'(b_pos_last), int'(qb[0].last));
        check("b_zero", int'(b_zero), int'(qb[0].zero));
        if (b_pos_ready) void'(qb.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && c_pos_valid) begin
      if (qc.size() == 0) begin
        check("c_unexpected_beat_pos", int'(c_pos), -1);
      end else begin
        check("c_pos", int'(c_pos), qc[0].pos);
        check("c_pos_last", int'(c_pos_last), int'(qc[0].last));
        check("c_zero", int'(c_zero), int'(qc[0].zero));
        if (c_pos_ready) void'(qc.pop_front());
      end
    end
  end

  task automatic send_a(input logic [7:0] v);
    int n = 0;
    a_in = v; a_in_valid = 1'b1;
    @(negedge clk);
    while (!a_in_ready && n < 50) begin @(negedge clk); n++; end
    check("a_send_ready", int'(a_in_ready), 1);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] v);
    int n = 0;
    b_in = v; b_in_valid = 1'b1;
    @(negedge clk);
    while (!b_in_ready && n < 50) begin @(negedge clk); n++; end
    check("b_send_ready", int'(b_in_ready), 1);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  task automatic send_c(input logic [15:0] v);
    int n = 0;
    c_in = v; c_in_valid = 1'b1;
    @(negedge clk);
    while (!c_in_ready && n < 50) begin @(negedge clk); n++; end
    check("c_send_ready", int'(c_in_ready), 1);
    @(posedge clk); #1;
    c_in_valid = 1'b0;
  endtask

  // Returns just after the edge following the last pop, so the DUTs have settled.
  task automatic drain();
    int n = 0;
    while ((qa.size() + qb.size() + qc.size()) != 0 && n < 100) begin
      @(posedge clk); n++;
    end
    check("drain_queues_empty", qa.size() + qb.size() + qc.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    a_in_valid = 0; a_pos_ready = 0; a_in = '0;
    b_in_valid = 0; b_pos_ready = 0; b_in = '0;
    c_in_valid = 0; c_pos_ready = 0; c_in = '0;

    // Reset state
    #1;
    check("rst_in_ready", int'(a_in_ready), 1);
    check("rst_pos_valid", int'(a_pos_valid), 0);
    check("rst_pos", int'(a_pos), 0);
    check("rst_pos_last", int'(a_pos_last), 0);
    check("rst_zero", int'(a_zero), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Zero vector: single beat, then idle
    a_pos_ready = 1'b1;
    qa.push_back(mk(0, 1, 1, 0));
    send_a(8'h00);
    drain();
    check("zero_idle_in_ready", int'(a_in_ready), 1);
    check("zero_idle_pos_valid", int'(a_pos_valid), 0);

    // 8'h22: pos 1 then pos 5 on the next cycle; in_ready high on the last beat
    qa.push_back(mk(1, 0, 0, 0));
    qa.push_back(mk(5, 1, 0, 1));
    send_a(8'h22);
    begin
      int n = 0;
      while (!(a_pos_valid && a_pos_last) && n < 20) begin @(negedge clk); n++; end
      check("walk_last_seen", int'(a_pos_valid && a_pos_last), 1);
      check("walk_last_in_ready", int'(a_in_ready), 1);
    end
    drain();

    // Backpressure on 8'h3F: held values checked by the monitor while pos_ready = 0
    a_pos_ready = 1'b0;
    for (int k = 0; k < 6; k++) qa.push_back(mk(k, k == 5, 0, 0));
    send_a(8'h3F);
    for (int k = 0; k < 14; k++) begin
      a_pos_ready = (k % 2 == 0);
      @(posedge clk); #1;
    end
    a_pos_ready = 1'b1;
    drain();

    // Back-to-back 8'h04 then 8'h80 with in_valid held high
    qa.push_back(mk(2, 1, 0, 0));
    qa.push_back(mk(7, 1, 0, 1));
    a_in = 8'h04; a_in_valid = 1'b1;
    begin
      int n = 0;
      @(negedge clk);
      while (!a_in_ready && n < 20) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      a_in = 8'h80;
      @(negedge clk);
      check("b2b_in_ready_on_last", int'(a_in_ready), 1);
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      a_in = 8'hFF;
    end
    drain();

    // MSB-first mode: 8'h81 -> 7 then 0
    b_pos_ready = 1'b1;
    qb.push_back(mk(7, 0, 0, 0));
    qb.push_back(mk(0, 1, 0, 0));
    send_b(8'h81);
    drain();

    // WIDTH 16: 16'h8000 -> single beat 15
    c_pos_ready = 1'b1;
    qc.push_back(mk(15, 1, 0, 0));
    send_c(16'h8000);
    drain();

    // Reset mid-scan while holding 8'h3F
    a_pos_ready = 1'b0;
    qa.push_back(mk(0, 0, 0, 0));
    send_a(8'h3F);
    @(posedge clk); #2;
    check("midscan_pos_valid_before", int'(a_pos_valid), 1);
    rst = 1'b1;
    #1;
    check("midscan_rst_pos_valid", int'(a_pos_valid), 0);
    check("midscan_rst_in_ready", int'(a_in_ready), 1);
    qa.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    a_pos_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("post_rst_no_beat", int'(a_pos_valid), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
